// File: rtl/quick_add_judge.sv
// Quick Add round controller: times each answer window, judges the answer against the adder sum and keeps score.
// Optional build macro STREAK_BONUS_EN: a correct answer after two or more consecutive correct answers scores +2.
module quick_add_judge #(
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
    parameter int unsigned RESULT_HOLD    = 50_000_000,
    parameter int unsigned MAX_ROUNDS     = 10,
    parameter int unsigned SCORE_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               submit,
    input  logic [7:0]         answer,
    input  logic [7:0]         sum,
    output logic               new_round,
    output logic               round_active,
    output logic               correct,
    output logic               wrong,
    output logic               timeout,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         round_num,
    output logic               done
);

    // One timer serves both the answer window and the result hold.
    localparam int unsigned TMAX = (TIMEOUT_CYCLES > RESULT_HOLD) ? TIMEOUT_CYCLES : RESULT_HOLD;
    localparam int unsigned TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(RESULT_HOLD - 1);
    localparam logic [3:0]    LAST_ROUND = 4'(MAX_ROUNDS);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, JUDGE, RESULT, DONE} state_t;

    state_t        state_r;
    logic [TW-1:0] timer_r;
    logic [7:0]    ans_q;
    logic [1:0]    score_inc_s;
    logic [3:0]    round_next_s;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] base,
                                                   input logic [1:0]         inc);
        logic [SCORE_W:0] total;
        total = {1'b0, base} + (SCORE_W+1)'(inc);
        if (total[SCORE_W]) begin
            sat_add = {SCORE_W{1'b1}};
        end else begin
            sat_add = total[SCORE_W-1:0];
        end
    endfunction

`ifdef STREAK_BONUS_EN
    logic [3:0] streak_r;
    logic       start_evt_s;
    logic       hit_evt_s;
    logic       miss_evt_s;

    // Streak events and the resulting score increment.
    always_comb begin
        start_evt_s = ((state_r == IDLE) || (state_r == DONE)) && start;
        hit_evt_s   = (state_r == JUDGE) && (ans_q == sum);
        miss_evt_s  = ((state_r == JUDGE) && (ans_q != sum)) ||
                      ((state_r == WAIT) && !submit && (timer_r == WAIT_LAST));
        if (streak_r >= 4'd2) begin
            score_inc_s = 2'd2;
        end else begin
            score_inc_s = 2'd1;
        end
    end

    // Consecutive-correct counter, saturating at 15.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_r <= 4'd0;
        end else if (start_evt_s || miss_evt_s) begin
            streak_r <= 4'd0;
        end else if (hit_evt_s && (streak_r != 4'd15)) begin
            streak_r <= streak_r + 4'd1;
        end else begin
            streak_r <= streak_r;
        end
    end
`else
    // Flat scoring: every correct answer is worth one point.
    always_comb begin
        score_inc_s = 2'd1;
    end
`endif

    // Round counter value after the current round completes.
    always_comb begin
        round_next_s = round_num + 4'd1;
    end

    // Game FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            timer_r      <= {TW{1'b0}};
            ans_q        <= 8'd0;
            new_round    <= 1'b0;
            round_active <= 1'b0;
            correct      <= 1'b0;
            wrong        <= 1'b0;
            timeout      <= 1'b0;
            score        <= {SCORE_W{1'b0}};
            round_num    <= 4'd0;
            done         <= 1'b0;
        end else begin
            new_round <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r   <= LOAD;
                        timer_r   <= {TW{1'b0}};
                        score     <= {SCORE_W{1'b0}};
                        round_num <= 4'd0;
                        done      <= 1'b0;
                        new_round <= 1'b1;
                    end
                end
                LOAD: begin
                    state_r      <= WAIT;
                    timer_r      <= {TW{1'b0}};
                    round_active <= 1'b1;
                end
                WAIT: begin
                    // A submit on the expiry cycle still gets judged.
                    if (submit) begin
                        state_r      <= JUDGE;
                        ans_q        <= answer;
                        round_active <= 1'b0;
                    end else if (timer_r == WAIT_LAST) begin
                        state_r      <= RESULT;
                        timer_r      <= {TW{1'b0}};
                        round_active <= 1'b0;
                        timeout      <= 1'b1;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                JUDGE: begin
                    state_r <= RESULT;
                    timer_r <= {TW{1'b0}};
                    if (ans_q == sum) begin
                        correct <= 1'b1;
                        score   <= sat_add(score, score_inc_s);
                    end else begin
                        wrong <= 1'b1;
                    end
                end
                RESULT: begin
                    if (timer_r == HOLD_LAST) begin
                        correct   <= 1'b0;
                        wrong     <= 1'b0;
                        timeout   <= 1'b0;
                        round_num <= round_next_s;
                        timer_r   <= {TW{1'b0}};
                        if (round_next_s == LAST_ROUND) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r   <= LOAD;
                            new_round <= 1'b1;
                        end
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    timer_r      <= {TW{1'b0}};
                    round_active <= 1'b0;
                    correct      <= 1'b0;
                    wrong        <= 1'b0;
                    timeout      <= 1'b0;
                    done         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quick_add_judge.sv
// Bench for quick_add_judge: random rounds scored by a game-level model, results checked by a queue-driven monitor.
module tb_quick_add_judge;

    localparam int T  = 20;
    localparam int H  = 4;
    localparam int MR = 3;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst, start, submit;
    logic [7:0]    answer, sum;
    logic          new_round, round_active, correct, wrong, timeout, done;
    logic [SW-1:0] score;
    logic [3:0]    round_num;

    logic          sat_start, sat_submit;
    logic [7:0]    sat_answer, sat_sum;
    logic          sat_new_round, sat_round_active, sat_correct, sat_wrong, sat_timeout, sat_done;
    logic [1:0]    sat_score;
    logic [3:0]    sat_round_num;

    always #5 clk = ~clk;

    quick_add_judge #(.TIMEOUT_CYCLES(T), .RESULT_HOLD(H), .MAX_ROUNDS(MR), .SCORE_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .submit(submit), .answer(answer), .sum(sum),
        .new_round(new_round), .round_active(round_active), .correct(correct), .wrong(wrong),
        .timeout(timeout), .score(score), .round_num(round_num), .done(done));

    // Narrow score and long game, so saturation is reachable.
    quick_add_judge #(.TIMEOUT_CYCLES(T), .RESULT_HOLD(H), .MAX_ROUNDS(5), .SCORE_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(sat_start), .submit(sat_submit), .answer(sat_answer), .sum(sat_sum),
        .new_round(sat_new_round), .round_active(sat_round_active), .correct(sat_correct),
        .wrong(sat_wrong), .timeout(sat_timeout), .score(sat_score), .round_num(sat_round_num),
        .done(sat_done));

    typedef struct {
        logic       c, w, t;
        logic [31:0] score;
        logic [31:0] rounds;
        logic       fin;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_score, m_rounds, m_streak;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    function automatic int bonus(input int streak);
        int inc;
        inc = 1;
`ifdef STREAK_BONUS_EN
        if (streak >= 2) inc = 2;
`endif
        return inc;
    endfunction

    function automatic void model_start();
        m_score  = 0;
        m_rounds = 0;
        m_streak = 0;
    endfunction

    function automatic exp_t model_round(input bit hit, input bit expired);
        exp_t e;
        e.c = !expired && hit;
        e.w = !expired && !hit;
        e.t = expired;
        if (e.c) begin
            m_score  = (m_score + bonus(m_streak) > 2**SW - 1) ? 2**SW - 1 : m_score + bonus(m_streak);
            m_streak = (m_streak < 15) ? m_streak + 1 : 15;
        end else begin
            m_streak = 0;
        end
        m_rounds++;
        e.score  = m_score;
        e.rounds = m_rounds;
        e.fin    = (m_rounds == MR);
        return e;
    endfunction

    bit   prev_flag = 1'b0;
    int   hold_cnt  = 0;
    exp_t cur;

    // Monitor: pops an expectation on each result and checks its length and the round hand-off.
    always @(negedge clk) begin
        if (correct || wrong || timeout) begin
            check("result_onehot", 32'(correct) + 32'(wrong) + 32'(timeout), 32'd1);
            if (!prev_flag) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got c%0b w%0b t%0b with no round pending", correct, wrong, timeout);
                end else begin
                    cur = q.pop_front();
                    check("res_correct", correct, cur.c);
                    check("res_wrong", wrong, cur.w);
                    check("res_timeout", timeout, cur.t);
                    check("res_score", score, cur.score);
                    check("res_round_num", round_num, cur.rounds - 1);
                end
                hold_cnt = 1;
            end else begin
                hold_cnt++;
            end
            prev_flag = 1'b1;
        end else begin
            if (prev_flag) begin
                check("hold_len", hold_cnt, H);
                check("round_after", round_num, cur.rounds);
                check("done_after", done, cur.fin);
                check("new_round_after", new_round, !cur.fin);
            end
            prev_flag = 1'b0;
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_start();
        check("start_new_round", new_round, 1);
        check("start_score_clear", score, 0);
        check("start_round_clear", round_num, 0);
        check("start_done_clear", done, 0);
        @(negedge clk);
        check("load_to_wait", round_active, 1);
    endtask

    task automatic play_round(input bit expired, input logic [7:0] s, input logic [7:0] a,
                              input int d, input bit stray);
        int n;
        sum = s;
        n = 0;
        while (!round_active && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!round_active) begin
            fail("wait_round_active");
            return;
        end
        q.push_back(model_round(a == s, expired));
        if (!expired) begin
            if (stray && d > 0) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (d - 1) @(negedge clk);
            end else begin
                repeat (d) @(negedge clk);
            end
            submit = 1'b1;
            answer = a;
            @(negedge clk);
            submit = 1'b0;
            answer = 8'($urandom);
            check("judge_gap", 32'(correct | wrong | timeout | round_active), 32'd0);
            @(negedge clk);
            check("submit_latency", correct | wrong, 1);
        end else begin
            repeat (T - 1) @(negedge clk);
            check("window_last_cycle", round_active, 1);
            @(negedge clk);
            check("timeout_cycle", timeout, 1);
        end
        if (stray) begin
            submit = 1'b1;
            answer = s;
            start  = 1'b1;
            @(negedge clk);
            submit = 1'b0;
            start  = 1'b0;
        end
        n = 0;
        while (!(new_round || done) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!(new_round || done)) fail("round_end_wait");
    endtask

    task automatic random_game();
        logic [7:0] s;
        do_start();
        for (int r = 0; r < MR; r++) begin
            s = 8'($urandom);
            play_round($urandom_range(0, 3) == 0, s, ($urandom_range(0, 1) == 1) ? s : 8'($urandom),
                       $urandom_range(0, T - 1), 1'($urandom_range(0, 1)));
        end
        check("game_done", done, 1);
        check("game_rounds", round_num, MR);
        check("game_score", score, m_score);
    endtask

    task automatic sat_game();
        int s, streak, n;
        sat_start = 1'b1;
        @(negedge clk);
        sat_start = 1'b0;
        s = 0;
        streak = 0;
        for (int r = 0; r < 5; r++) begin
            n = 0;
            while (!sat_round_active && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (!sat_round_active) begin
                fail("sat_wait_active");
                return;
            end
            sat_sum    = 8'($urandom);
            sat_answer = sat_sum;
            sat_submit = 1'b1;
            @(negedge clk);
            sat_submit = 1'b0;
            s = (s + bonus(streak) > 3) ? 3 : s + bonus(streak);
            streak++;
            @(negedge clk);
            check("sat_correct", sat_correct, 1);
            check("sat_score", sat_score, s);
            n = 0;
            while (!(sat_new_round || sat_done) && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!(sat_new_round || sat_done)) fail("sat_round_end");
        end
        check("sat_done", sat_done, 1);
        check("sat_final_score", sat_score, 3);
    endtask

    initial begin
        int g2_exp;
        rst = 1'b1; start = 1'b0; submit = 1'b0; answer = 8'd0; sum = 8'd0;
        sat_start = 1'b0; sat_submit = 1'b0; sat_answer = 8'd0; sat_sum = 8'd0;
        model_start();
        repeat (3) @(negedge clk);
        check("rst_new_round", new_round, 0);
        check("rst_round_active", round_active, 0);
        check("rst_flags", 32'(correct | wrong | timeout), 32'd0);
        check("rst_score", score, 0);
        check("rst_round_num", round_num, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        // Submit while idle must do nothing.
        submit = 1'b1; answer = 8'h2A; sum = 8'h2A;
        @(negedge clk);
        submit = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_submit_active", round_active, 0);
        check("idle_submit_new_round", new_round, 0);
        check("idle_submit_score", score, 0);
        check("idle_submit_flags", 32'(correct | wrong | timeout), 32'd0);

        // Directed game: correct, wrong, timeout.
        do_start();
        play_round(1'b0, 8'h2A, 8'h2A, $urandom_range(0, T - 1), 1'b1);
        play_round(1'b0, 8'hFF, 8'hFE, $urandom_range(0, T - 1), 1'b0);
        play_round(1'b1, 8'h55, 8'h55, 0, 1'b1);
        check("g1_done", done, 1);
        check("g1_rounds", round_num, 3);
        check("g1_score", score, 1);

        // Three correct rounds, one on the expiry cycle and one with a stray start in WAIT.
        do_start();
        play_round(1'b0, 8'h10, 8'h10, $urandom_range(1, T - 2), 1'b1);
        play_round(1'b0, 8'h80, 8'h80, T - 1, 1'b0);
        play_round(1'b0, 8'h00, 8'h00, 0, 1'b0);
`ifdef STREAK_BONUS_EN
        g2_exp = 4;
`else
        g2_exp = 3;
`endif
        check("g2_done", done, 1);
        check("g2_rounds", round_num, 3);
        check("g2_score", score, g2_exp);
        repeat (5) @(negedge clk);
        check("done_hold", done, 1);
        check("done_score_hold", score, g2_exp);

        for (int g = 0; g < 4; g++) random_game();

        // Reset in the middle of an answer window.
        do_start();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_start();
        check("midrst_active", round_active, 0);
        check("midrst_score", score, 0);
        check("midrst_round_num", round_num, 0);
        check("midrst_other", 32'(new_round | correct | wrong | timeout | done), 32'd0);
        repeat (5) @(negedge clk);
        check("midrst_no_autostart", 32'(round_active | new_round), 32'd0);
        random_game();

        sat_game();

        repeat (2) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
